led_panel_capture: RTL and testbench
====================================

LED_PANEL_CAPTURE -- requirements
Module: led_panel_capture

Interface
REQ-001 Parameter: COLS, default 32; number of shift-clock bits per row line (32 = two 16-pixel half-lines interleaved).
REQ-002 clk  in  1  Single system clock; all logic on its rising edge.
REQ-003 reset  in  1  Synchronous active-high reset.
REQ-004 red_in / green_in / blue_in  in  1 each  Serial pixel data from the panel driver.
REQ-005 sclk_in  in  1  Shift clock; data is captured on its rising edge.
REQ-006 latch_in  in  1  Active-high latch strobe; shift contents move to the row store.
REQ-007 blank_in  in  1  Active-high blank; low = row lit.
REQ-008 aclk_in  in  1  Row-address advance; acts on its rising edge.
REQ-009 arst_in  in  1  Row-address reset; level-sensitive, active-high.
REQ-010 rd_row  in  2  Read-port row address.
REQ-011 rd_col  in  $clog2(COLS)  Read-port bit position.
REQ-012 rd_rgb  out  3  Stored {r,g,b} at (rd_row, rd_col); registered.
REQ-013 row_latched  out  1  One-cycle pulse when a row is written to the store.
REQ-014 latched_row  out  2  Row index of the most recent store write.
REQ-015 frame_done  out  1  One-cycle pulse when row 3 is written.
REQ-016 len_err  out  1  Sticky flag: a latch arrived with bit count != COLS.
REQ-017 lit  out  1  Registered ~blank_in, gated by the RUN state.

Function
REQ-018 All panel inputs are registered into stage s1, then s2; edges are s1 & ~s2.
REQ-019 sclk rising edge: the R, G and B shift registers each shift {sr[COLS-2:0], s2_data}, so the bit present one sample before the rise is captured.
REQ-020 After COLS shifts, the first bit shifted sits at index COLS-1 and the last at index 0.
REQ-021 bit_cnt (6 bit) increments per sclk edge and saturates at 63.
REQ-022 Row address: s1 arst high -> row_addr = 0; aclk rising edge with arst low -> row_addr + 1, mod 4; arst wins when both occur.
REQ-023 FSM states: WAIT_SYNC and RUN; WAIT_SYNC -> RUN on the first s1 arst high; RUN is left only on reset.
REQ-024 In WAIT_SYNC, shifting and bit counting run, but latch edges do not write the store, do not pulse outputs, and do not set len_err; lit = 0.
REQ-025 Latch rising edge in RUN, same cycle: store[row_addr] <= the pre-shift shift-register contents; latched_row <= row_addr; row_latched = 1; frame_done = 1 if row_addr == 3; len_err is set if bit_cnt != COLS.
REQ-026 On a latch edge, bit_cnt <= 0, or <= 1 if an sclk edge coincides; the coinciding shift still occurs.
REQ-027 A latch edge and an aclk edge in the same cycle write the store using the pre-increment row_addr.
REQ-028 Read port: rd_rgb <= {R,G,B}[rd_row][rd_col], one-cycle latency; a read of the row being written returns the pre-write data.
REQ-029 Store capacity is 4 x COLS x 3 bits of flops; no back-pressure; latches are never dropped in RUN.

Reset
REQ-030 Reset clears s1, s2, shift registers, bit_cnt, row_addr and the store to 0; state = WAIT_SYNC.
REQ-031 Reset drives all outputs to 0: rd_rgb, row_latched, latched_row, frame_done, len_err and lit.
REQ-032 Edge detection is suppressed for the first 2 cycles after reset deasserts, so no false edges come from idle-high inputs such as sclk.
REQ-033 Reset asserted mid-row discards the partial row; len_err clears.

Verification
REQ-034 After reset, sclk held high, arst pulsed -> no shift, bit_cnt = 0, state RUN, no row_latched pulse.
REQ-035 arst; then 32 sclk pulses with red = 1 only on bits 1 and 2 (pattern 0x6000_0000 first-in-MSB); latch -> row_latched = 1, latched_row = 0; reading (0,30) and (0,29) -> rd_rgb = 3'b100; other columns -> 0.
REQ-036 Four full rows framed by arst, then aclk x3, each with a latch -> frame_done pulses once, coincident with latched_row = 3; len_err = 0.
REQ-037 Latch after 31 sclk pulses -> len_err = 1 and stays 1 through later good rows until reset.
REQ-038 arst and aclk rising together with row_addr = 2 -> row_addr = 0; latch in the same cycle as an aclk edge writes the old row.
REQ-039 Latch edges before any arst -> no store write, row_latched = 0, lit = 0 with blank_in low.

Source files
------------

// File: rtl/led_panel_capture.sv
// Captures the serial RGB row stream of a HUB-style LED panel driver into a
// 4-row store with a registered random-access read port and status flags.
module led_panel_capture #(
  parameter int COLS = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    red_in,
  input  logic                    green_in,
  input  logic                    blue_in,
  input  logic                    sclk_in,
  input  logic                    latch_in,
  input  logic                    blank_in,
  input  logic                    aclk_in,
  input  logic                    arst_in,
  input  logic [1:0]              rd_row,
  input  logic [$clog2(COLS)-1:0] rd_col,
  output logic [2:0]              rd_rgb,
  output logic                    row_latched,
  output logic [1:0]              latched_row,
  output logic                    frame_done,
  output logic                    len_err,
  output logic                    lit
);

  typedef enum logic {WAIT_SYNC, RUN} state_t;

  state_t     state_reg, state_next;
  // s1 = {r, g, b, sclk, latch, aclk, blank, arst}; s2 keeps only what edges/shifts need
  logic [7:0] s1_reg;
  logic [5:0] s2_reg;
  logic [1:0] warm_reg;
  logic       edges_en;
  logic       sclk_edge, latch_edge, aclk_edge;
  logic       store_we;
  logic [5:0] bit_cnt_reg;
  logic [1:0] row_addr_reg;
  logic [1:0] latched_row_reg;
  logic       row_latched_reg, frame_done_reg, len_err_reg, lit_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_reg   <= '0;
      s2_reg   <= '0;
      warm_reg <= '0;
    end else begin
      s1_reg <= {red_in, green_in, blue_in, sclk_in, latch_in, aclk_in, blank_in, arst_in};
      s2_reg <= s1_reg[7:2];
      if (warm_reg != 2'd2) warm_reg <= warm_reg + 2'd1;
    end
  end

  // s2 still holds reset zeros for two cycles; an idle-high line would look like a rise
  assign edges_en   = (warm_reg == 2'd2);
  assign sclk_edge  = edges_en & s1_reg[4] & ~s2_reg[2];
  assign latch_edge = edges_en & s1_reg[3] & ~s2_reg[1];
  assign aclk_edge  = edges_en & s1_reg[2] & ~s2_reg[0];

  always_ff @(posedge clk) begin
    if (reset) state_reg <= WAIT_SYNC;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    store_we   = 1'b0;
    case (state_reg)
      WAIT_SYNC: if (s1_reg[0]) state_next = RUN;
      RUN:       store_we = latch_edge;
      default:   state_next = WAIT_SYNC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_reg     <= '0;
      row_addr_reg    <= '0;
      latched_row_reg <= '0;
      row_latched_reg <= 1'b0;
      frame_done_reg  <= 1'b0;
      len_err_reg     <= 1'b0;
      lit_reg         <= 1'b0;
    end else begin
      if (latch_edge)
        bit_cnt_reg <= sclk_edge ? 6'd1 : 6'd0;
      else if (sclk_edge && bit_cnt_reg != 6'd63)
        bit_cnt_reg <= bit_cnt_reg + 6'd1;

      if (s1_reg[0])     row_addr_reg <= '0;
      else if (aclk_edge) row_addr_reg <= row_addr_reg + 2'd1;

      row_latched_reg <= store_we;
      frame_done_reg  <= store_we && (row_addr_reg == 2'd3);
      if (store_we) latched_row_reg <= row_addr_reg;
      if (store_we && bit_cnt_reg != 6'(COLS)) len_err_reg <= 1'b1;
      lit_reg <= (state_reg == RUN) && !s1_reg[1];
    end
  end

  // One shift register, row store and read bit per colour; gi 0/1/2 = blue/green/red
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [COLS-1:0] sr_reg;
      logic [COLS-1:0] store_reg [4];
      logic            rd_bit_reg;

      always_ff @(posedge clk) begin
        if (reset) begin
          sr_reg     <= '0;
          rd_bit_reg <= 1'b0;
          for (int r = 0; r < 4; r++) store_reg[r] <= '0;
        end else begin
          if (sclk_edge) sr_reg <= {sr_reg[COLS-2:0], s2_reg[3+gi]};
          if (store_we)  store_reg[row_addr_reg] <= sr_reg;
          rd_bit_reg <= store_reg[rd_row][rd_col];
        end
      end

      assign rd_rgb[gi] = rd_bit_reg;
    end
  endgenerate

  assign row_latched = row_latched_reg;
  assign latched_row = latched_row_reg;
  assign frame_done  = frame_done_reg;
  assign len_err     = len_err_reg;
  assign lit         = lit_reg;

endmodule

// File: tb/tb_led_panel_capture.sv
// Bench for led_panel_capture: directed panel-protocol sequences plus random
// rows, compared against a bit-history model of the panel stream.
module tb_led_panel_capture;
  localparam int COLS = 32;
  localparam int CW   = $clog2(COLS);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          red_in = 0, green_in = 0, blue_in = 0;
  logic          sclk_in = 1'b1, latch_in = 0, blank_in = 0, aclk_in = 0, arst_in = 0;
  logic [1:0]    rd_row = '0;
  logic [CW-1:0] rd_col = '0;
  logic [2:0]    rd_rgb;
  logic          row_latched, frame_done, len_err, lit;
  logic [1:0]    latched_row;

  always #5 clk = ~clk;

  led_panel_capture #(.COLS(COLS)) dut (
    .clk(clk), .reset(reset),
    .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .sclk_in(sclk_in), .latch_in(latch_in), .blank_in(blank_in),
    .aclk_in(aclk_in), .arst_in(arst_in),
    .rd_row(rd_row), .rd_col(rd_col), .rd_rgb(rd_rgb),
    .row_latched(row_latched), .latched_row(latched_row),
    .frame_done(frame_done), .len_err(len_err), .lit(lit)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Pulse monitor
  int         mon_latches = 0, mon_frames = 0;
  logic [1:0] mon_last_row = '0, mon_frame_row = '0;
  always @(negedge clk) begin
    if (!reset) begin
      if (row_latched) begin mon_latches++; mon_last_row = latched_row; end
      if (frame_done)  begin mon_frames++;  mon_frame_row = latched_row; end
    end
  end

  // Model: history of shifted {r,g,b} values, newest last
  logic [2:0] hist[$];
  logic [2:0] m_store [4][COLS];
  int         m_cnt, m_row, m_latches = 0, m_frames = 0;
  logic [1:0] m_last_row = '0;
  bit         m_synced, m_err;

  typedef struct {
    int         row;
    int         col;
    logic [2:0] exp;
  } rd_vec_t;
  rd_vec_t vecs[6];

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  function automatic logic [2:0] sr_bit(input int i);
    if (i < hist.size()) return hist[hist.size()-1-i];
    return 3'b000;
  endfunction

  task automatic model_clear();
    hist.delete();
    foreach (m_store[r, c]) m_store[r][c] = 3'b000;
    m_cnt = 0; m_row = 0; m_synced = 0; m_err = 0;
  endtask

  task automatic model_shift(input logic [2:0] rgb);
    hist.push_back(rgb);
    if (hist.size() > COLS) void'(hist.pop_front());
    if (m_cnt < 63) m_cnt++;
  endtask

  task automatic model_latch(input bit with_aclk);
    $display("latch: row=%0d bits=%0d synced=%0d aclk=%0d", m_row, m_cnt, m_synced, with_aclk);
    if (m_synced) begin
      for (int i = 0; i < COLS; i++) m_store[m_row][i] = sr_bit(i);
      m_latches++;
      m_last_row = 2'(m_row);
      if (m_row == 3) m_frames++;
      if (m_cnt != COLS) m_err = 1;
    end
    m_cnt = 0;
    if (with_aclk) m_row = (m_row + 1) % 4;
  endtask

  task automatic post_latch_checks();
    check("latch_pulses", mon_latches, m_latches);
    check("frame_pulses", mon_frames, m_frames);
    if (m_synced) check("latched_row", mon_last_row, m_last_row);
    check("len_err", len_err, m_err);
  endtask

  task automatic sclk_bit(input logic [2:0] rgb);
    {red_in, green_in, blue_in} = rgb;
    sclk_in = 1'b0; tick(3);
    sclk_in = 1'b1; tick(3);
    model_shift(rgb);
  endtask

  task automatic shift_random(input int nbits);
    for (int k = 0; k < nbits; k++) sclk_bit(3'($urandom_range(0, 7)));
  endtask

  task automatic latch_row(input bit with_aclk);
    latch_in = 1'b1; aclk_in = with_aclk; tick(4);
    latch_in = 1'b0; aclk_in = 1'b0;      tick(3);
    model_latch(with_aclk);
    post_latch_checks();
  endtask

  // Latch rising in the same cycle as an sclk rise
  task automatic latch_with_sclk(input logic [2:0] rgb);
    {red_in, green_in, blue_in} = rgb;
    sclk_in = 1'b0; tick(3);
    sclk_in = 1'b1; latch_in = 1'b1; tick(4);
    latch_in = 1'b0; tick(3);
    model_latch(1'b0);
    model_shift(rgb);
    post_latch_checks();
  endtask

  task automatic aclk_pulse();
    aclk_in = 1'b1; tick(3);
    aclk_in = 1'b0; tick(3);
    m_row = (m_row + 1) % 4;
  endtask

  task automatic arst_pulse(input bit with_aclk);
    arst_in = 1'b1; aclk_in = with_aclk; tick(3);
    arst_in = 1'b0; aclk_in = 1'b0;      tick(3);
    m_row = 0; m_synced = 1;
  endtask

  task automatic read_check(input int r, input int c, input logic [2:0] exp);
    rd_row = 2'(r); rd_col = CW'(c);
    tick(1);
    check($sformatf("rd_rgb[%0d][%0d]", r, c), rd_rgb, exp);
  endtask

  task automatic read_all();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < COLS; c++) read_check(r, c, m_store[r][c]);
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(3);
    model_clear();
    check("rst_rd_rgb", rd_rgb, 3'b000);
    check("rst_row_latched", row_latched, 1'b0);
    check("rst_latched_row", latched_row, 2'b00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_len_err", len_err, 1'b0);
    check("rst_lit", lit, 1'b0);
    reset = 1'b0; tick(4);
  endtask

  initial begin
    vecs[0] = '{0, 30, 3'b100};
    vecs[1] = '{0, 29, 3'b100};
    vecs[2] = '{0, 31, 3'b000};
    vecs[3] = '{0, 28, 3'b000};
    vecs[4] = '{0, 0,  3'b000};
    vecs[5] = '{1, 30, 3'b000};

    // Reset with sclk idling high; no false edge afterwards
    do_reset();

    // Latches before any arst are ignored; lit stays off though blank is low
    shift_random(COLS);
    latch_row(1'b0);
    check("presync_lit", lit, 1'b0);
    read_check(0, 0, 3'b000);

    // arst with sclk held high: sync, no pulse
    arst_pulse(1'b0);
    check("sync_no_pulse", mon_latches, m_latches);
    check("sync_lit", lit, 1'b1);

    // Red on bits 1 and 2 only (0x6000_0000 first-in-MSB)
    for (int k = 0; k < COLS; k++) sclk_bit((k == 1 || k == 2) ? 3'b100 : 3'b000);
    latch_row(1'b0);
    check("first_row_idx", mon_last_row, 2'd0);
    foreach (vecs[i]) read_check(vecs[i].row, vecs[i].col, vecs[i].exp);

    // Full frame: frame_done once, coincident with row 3
    begin
      int f0 = mon_frames;
      arst_pulse(1'b0);
      for (int r = 0; r < 4; r++) begin
        shift_random(COLS);
        latch_row(1'b0);
        if (r < 3) aclk_pulse();
      end
      check("frame_once", mon_frames - f0, 1);
      check("frame_row", mon_frame_row, 2'd3);
      check("frame_len_err", len_err, 1'b0);
      read_all();
    end

    // arst + aclk together at row 2 -> row 0; latch + aclk writes old row
    arst_pulse(1'b0);
    aclk_pulse(); aclk_pulse();
    arst_pulse(1'b1);
    shift_random(COLS);
    latch_row(1'b1);
    check("arst_wins_row", mon_last_row, 2'd0);
    shift_random(COLS);
    latch_row(1'b0);
    check("latch_aclk_next", mon_last_row, 2'd1);
    read_all();

    // Short row sets sticky len_err; latch coincident with an sclk rise
    shift_random(COLS - 1);
    latch_row(1'b0);
    check("short_len_err", len_err, 1'b1);
    shift_random(COLS - 1);
    latch_with_sclk(3'($urandom_range(0, 7)));
    shift_random(COLS - 1);
    latch_row(1'b1);
    check("sticky_len_err", len_err, 1'b1);

    // Random rows against the model; fresh reset so len_err can be observed again
    do_reset();
    arst_pulse(1'b0);
    for (int it = 0; it < 8; it++) begin
      int nb = ($urandom_range(0, 3) == 0) ? COLS - 1 + 2 * $urandom_range(0, 1) : COLS;
      shift_random(nb);
      latch_row(1'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) aclk_pulse();
    end
    read_all();

    // Reset mid-row discards the partial row and clears len_err
    shift_random(5);
    do_reset();
    check("midrow_len_err", len_err, 1'b0);
    read_all();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
